dmem_responder: RTL and testbench

- Data-memory responder serving the CPU's stage-3 load/store interface (MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en, MEM_data).
- Single-port word RAM with byte/half/word lane handling, combinational read and synchronous write.
- Includes a post-reset RAM-clear state machine and a sticky fault reporter for misaligned, out-of-range and illegal accesses.
- Sits between the CPU top level and the SoC data bus.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets and the RAM-clear state type.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] MMIO_CYC = 4'h0;
  localparam logic [3:0] MMIO_LDS = 4'h4;
  localparam logic [3:0] MMIO_STS = 4'h8;
  localparam logic [3:0] MMIO_FLT = 4'hC;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory responder: store byte enables and data
// replication, load lane extraction with sign/zero extension, and alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        illegal_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
  assign rhalf = rword_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = '0;
    rdata_o   = '0;
    illegal_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = zext_i ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        illegal_o = lane_i[0];
        be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        rdata_o   = zext_i ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        illegal_o = |lane_i;
        be_o      = 4'b1111;
        wdata_o   = wdata_i;
        rdata_o   = rword_i;
      end
      SZ_RSVD: illegal_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with lane handling, post-reset RAM clear and
// sticky fault reporting. Define DMEM_MMIO_EN to add the read-only counter window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  state_e          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            mem_ready_q;
  logic            mem_fault_q;
  logic [31:0]     fault_addr_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rword;
  logic            ready;
  logic            both;
  logic            req;
  logic            mmio_hit;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     rdata_ext;
  logic            illegal;
  logic            ram_ok;
  logic            acc_ok;
  logic            ram_we;
  logic            fault_now;

  // BASE_ADDR is aligned to the RAM size, so an address below it wraps the
  // subtraction to a value far above RAM_BYTES and lands out of range.
  assign offset   = MEM_addr - BASE_ADDR;
  assign in_range = offset < RAM_BYTES;
  assign word_idx = offset[AW+1:2];
  assign rword    = mem_q[word_idx];

  assign ready    = (state_q == READY);
  assign both     = MEM_rd_en & MEM_wr_en;
  assign req      = MEM_rd_en | MEM_wr_en;
  assign mmio_hit = (MEM_addr[31:4] == MMIO_BASE[31:4]);
  assign ram_ok   = in_range & ~illegal & ~mmio_hit;

  dmem_lane_align u_align (
    .size_i    (MEM_type[1:0]),
    .zext_i    (MEM_type[2]),
    .lane_i    (offset[1:0]),
    .wdata_i   (MEM_WR_out),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (rdata_ext),
    .illegal_o (illegal)
  );

`ifdef DMEM_MMIO_EN
  logic        mmio_ok;
  logic [31:0] cyc_q;
  logic [31:0] lds_q;
  logic [31:0] sts_q;

  assign mmio_ok = mmio_hit & MEM_rd_en & (MEM_type[1:0] == SZ_WORD) & ~illegal;
  assign acc_ok  = ~both & (ram_ok | mmio_ok);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cyc_q <= '0;
      lds_q <= '0;
      sts_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (ready && MEM_rd_en && acc_ok) lds_q <= lds_q + 32'd1;
      if (ram_we)                       sts_q <= sts_q + 32'd1;
    end
  end
`else
  assign acc_ok = ~both & ram_ok;
`endif

  assign ram_we    = ready & MEM_wr_en & acc_ok;
  assign fault_now = ready & req & ~acc_ok;

  always_comb begin
    MEM_data = '0;
    if (ready && MEM_rd_en && acc_ok) begin
`ifdef DMEM_MMIO_EN
      if (mmio_ok) begin
        case (MEM_addr[3:0])
          MMIO_CYC: MEM_data = cyc_q;
          MMIO_LDS: MEM_data = lds_q;
          MMIO_STS: MEM_data = sts_q;
          MMIO_FLT: MEM_data = {31'b0, mem_fault_q};
          default:  MEM_data = '0;
        endcase
      end else begin
        MEM_data = rdata_ext;
      end
`else
      MEM_data = rdata_ext;
`endif
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      mem_ready_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      clr_idx_q <= clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
        state_q     <= READY;
        mem_ready_q <= 1'b1;
      end
    end
  end

  // A fault in the same cycle as fault_clr wins and becomes the new first fault.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem_fault_q  <= 1'b0;
      fault_addr_q <= '0;
    end else if (fault_now) begin
      mem_fault_q <= 1'b1;
      if (!mem_fault_q || fault_clr) fault_addr_q <= MEM_addr;
    end else if (fault_clr) begin
      mem_fault_q  <= 1'b0;
      fault_addr_q <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign mem_ready  = mem_ready_q;
  assign mem_fault  = mem_fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with a 16-word RAM; also
// exercises the counter window when DMEM_MMIO_EN is defined.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] MEM_addr = '0;
  logic [31:0] MEM_WR_out = '0;
  logic [2:0]  MEM_type = '0;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic        mem_ready;
  logic        mem_fault;
  logic [31:0] fault_addr;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (16),
    .BASE_ADDR   (32'h0000_0000),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .MEM_addr   (MEM_addr),
    .MEM_WR_out (MEM_WR_out),
    .MEM_type   (MEM_type),
    .MEM_rd_en  (MEM_rd_en),
    .MEM_wr_en  (MEM_wr_en),
    .MEM_data   (MEM_data),
    .mem_ready  (mem_ready),
    .mem_fault  (mem_fault),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  always #5 CLK = ~CLK;

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
    MEM_rd_en  = rd;
    MEM_wr_en  = wr;
    MEM_type   = ty;
    MEM_addr   = a;
    MEM_WR_out = d;
  endtask

  // Apply a request half a cycle before the next rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    set_req(rd, wr, ty, a, d);
    #1;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    fault_clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    set_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b exp 0", mem_ready); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got %b exp 0", mem_fault); end
    checks++; if (fault_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_faddr got %h exp 0", fault_addr); end
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got %h exp 0", MEM_data); end
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) set_req(1'b0, 1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF);
      if (i == 5) begin
        set_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL clr_load got %h exp 0", MEM_data); end
      end
      if (i == 7) set_req(1'b0, 1'b1, 3'b010, 32'h3, 32'h1);
      step;
      checks++; if (mem_ready !== (i == 16)) begin errors++; $display("[TB] FAIL clr_ready cyc %0d got %b exp %b", i, mem_ready, (i == 16)); end
      checks++; if (mem_fault !== 1'b0) begin errors++; $display("[TB] FAIL clr_fault cyc %0d got %b exp 0", i, mem_fault); end
    end
  endtask

  task automatic test_clear_result;
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL cleared_w0 got %h exp 0", MEM_data); end
    drive(1'b1, 1'b0, 3'b010, 32'h3C, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL cleared_w15 got %h exp 0", MEM_data); end
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL idle_data got %h exp 0", MEM_data); end
    step;
  endtask

  task automatic test_store_lanes;
    drive(1'b0, 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF); step;
    drive(1'b0, 1'b1, 3'b000, 32'h9, 32'hABCD_EF55); step;
    drive(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (MEM_data !== 32'hDEAD_55EF) begin errors++; $display("[TB] FAIL ld_word8 got %h exp DEAD55EF", MEM_data); end
    drive(1'b1, 1'b0, 3'b000, 32'h9, 32'h0);
    checks++; if (MEM_data !== 32'h0000_0055) begin errors++; $display("[TB] FAIL ld_sbyte9 got %h exp 00000055", MEM_data); end
    drive(1'b1, 1'b0, 3'b001, 32'hA, 32'h0);
    checks++; if (MEM_data !== 32'hFFFF_DEAD) begin errors++; $display("[TB] FAIL ld_shalfA got %h exp FFFFDEAD", MEM_data); end
    drive(1'b1, 1'b0, 3'b101, 32'hA, 32'h0);
    checks++; if (MEM_data !== 32'h0000_DEAD) begin errors++; $display("[TB] FAIL ld_uhalfA got %h exp 0000DEAD", MEM_data); end
    drive(1'b1, 1'b0, 3'b000, 32'h8, 32'h0);
    checks++; if (MEM_data !== 32'hFFFF_FFEF) begin errors++; $display("[TB] FAIL ld_sbyte8 got %h exp FFFFFFEF", MEM_data); end
    drive(1'b1, 1'b0, 3'b100, 32'h8, 32'h0);
    checks++; if (MEM_data !== 32'h0000_00EF) begin errors++; $display("[TB] FAIL ld_ubyte8 got %h exp 000000EF", MEM_data); end
    drive(1'b0, 1'b1, 3'b001, 32'h6, 32'hFFFF_8001); step;
    drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    checks++; if (MEM_data !== 32'h8001_0000) begin errors++; $display("[TB] FAIL ld_word4 got %h exp 80010000", MEM_data); end
    drive(1'b1, 1'b0, 3'b001, 32'h6, 32'h0);
    checks++; if (MEM_data !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL ld_shalf6 got %h exp FFFF8001", MEM_data); end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678); step;
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (MEM_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL raw_word10 got %h exp 12345678", MEM_data); end
    step;
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("[TB] FAIL legal_nofault got %b exp 0", mem_fault); end
  endtask

  task automatic test_faults;
    drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL mis_data got %h exp 0", MEM_data); end
    step;
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault got %b exp 1", mem_fault); end
    checks++; if (fault_addr !== 32'h6) begin errors++; $display("[TB] FAIL mis_faddr got %h exp 6", fault_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL oor_data got %h exp 0", MEM_data); end
    step;
    checks++; if (fault_addr !== 32'h6) begin errors++; $display("[TB] FAIL first_wins got %h exp 6", fault_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'h3, 32'h0);
    fault_clr = 1'b1;
    step;
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_fault got %b exp 1", mem_fault); end
    checks++; if (fault_addr !== 32'h3) begin errors++; $display("[TB] FAIL clr_vs_faddr got %h exp 3", fault_addr); end
    @(negedge CLK); fault_clr = 1'b1; step;
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("[TB] FAIL clr_fault got %b exp 0", mem_fault); end
    checks++; if (fault_addr !== 32'h0) begin errors++; $display("[TB] FAIL clr_faddr got %h exp 0", fault_addr); end
    drive(1'b1, 1'b0, 3'b011, 32'h8, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_data got %h exp 0", MEM_data); end
    step;
    checks++; if (fault_addr !== 32'h8) begin errors++; $display("[TB] FAIL rsvd_faddr got %h exp 8", fault_addr); end
    @(negedge CLK); fault_clr = 1'b1; step;
    drive(1'b1, 1'b0, 3'b001, 32'h9, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL half_mis_data got %h exp 0", MEM_data); end
    step;
    checks++; if (fault_addr !== 32'h9) begin errors++; $display("[TB] FAIL half_mis_faddr got %h exp 9", fault_addr); end
    @(negedge CLK); fault_clr = 1'b1; step;
    drive(1'b0, 1'b1, 3'b010, 32'h11, 32'hFFFF_FFFF); step;
    checks++; if (fault_addr !== 32'h11) begin errors++; $display("[TB] FAIL st_mis_faddr got %h exp 11", fault_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (MEM_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL st_mis_nowrite got %h exp 12345678", MEM_data); end
    fault_clr = 1'b1; step;
  endtask

  task automatic test_rd_wr_both;
    drive(1'b1, 1'b1, 3'b010, 32'h4, 32'h0000_1234);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL both_data got %h exp 0", MEM_data); end
    step;
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL both_fault got %b exp 1", mem_fault); end
    checks++; if (fault_addr !== 32'h4) begin errors++; $display("[TB] FAIL both_faddr got %h exp 4", fault_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    checks++; if (MEM_data !== 32'h8001_0000) begin errors++; $display("[TB] FAIL both_nowrite got %h exp 80010000", MEM_data); end
    fault_clr = 1'b1; step;
  endtask

  task automatic test_mmio;
`ifdef DMEM_MMIO_EN
    @(negedge CLK); Reset = 1'b0;
    @(negedge CLK); Reset = 1'b1;
    repeat (16) @(posedge CLK);
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL mmio_ready got %b exp 1", mem_ready); end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'hFFFF_0004, 32'h0);
    checks++; if (MEM_data !== 32'd3) begin errors++; $display("[TB] FAIL mmio_lds got %h exp 3", MEM_data); end
    drive(1'b1, 1'b0, 3'b010, 32'hFFFF_0008, 32'h0);
    checks++; if (MEM_data !== 32'd0) begin errors++; $display("[TB] FAIL mmio_sts got %h exp 0", MEM_data); end
    drive(1'b0, 1'b1, 3'b010, 32'hFFFF_0000, 32'h5); step;
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL mmio_st_fault got %b exp 1", mem_fault); end
    checks++; if (fault_addr !== 32'hFFFF_0000) begin errors++; $display("[TB] FAIL mmio_st_faddr got %h exp FFFF0000", fault_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'hFFFF_000C, 32'h0);
    checks++; if (MEM_data !== 32'd1) begin errors++; $display("[TB] FAIL mmio_flt got %h exp 1", MEM_data); end
    step;
`else
    drive(1'b1, 1'b0, 3'b010, 32'hFFFF_0000, 32'h0);
    checks++; if (MEM_data !== 32'h0) begin errors++; $display("[TB] FAIL nommio_data got %h exp 0", MEM_data); end
    step;
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL nommio_fault got %b exp 1", mem_fault); end
    checks++; if (fault_addr !== 32'hFFFF_0000) begin errors++; $display("[TB] FAIL nommio_faddr got %h exp FFFF0000", fault_addr); end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_clear_result;
    test_store_lanes;
    test_faults;
    test_rd_wr_both;
    test_mmio;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
